modulo_corrector: RTL and testbench

Single-error-correct / double-error-detect stage for the extended Hamming(8,4) link. It sits directly upstream of the 8-to-4 decoder (modulo_decodi).
- Accepts a received 8-bit codeword and computes the 3-bit syndrome and the global parity.
- Flips the faulty bit on a single error, or flags an uncorrectable double error.
- Delivers the corrected codeword over a valid/ready handshake with a 2-stage pipeline.
- Keeps saturating error-event counters.

---
 rtl/pkg_hamming.sv | 40 ++++
 rtl/calc_sindrome.sv | 13 +
 rtl/modulo_corrector.sv | 106 ++++++++++
 tb/tb_modulo_corrector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pkg_hamming.sv
// Shared definitions for the extended Hamming(8,4) link: widths, bit positions,
// syndrome computation and error classification.
package pkg_hamming;

  localparam int unsigned COD_W = 8;
  localparam int unsigned DAT_W = 4;

  // cod[i-1] holds Hamming position i; cod[7] is global even parity.
  localparam int unsigned POS_P1 = 0;
  localparam int unsigned POS_P2 = 1;
  localparam int unsigned POS_P4 = 3;
  localparam int unsigned POS_D0 = 2;
  localparam int unsigned POS_D1 = 4;
  localparam int unsigned POS_D2 = 5;
  localparam int unsigned POS_D3 = 6;
  localparam int unsigned POS_PG = 7;

  typedef enum logic [1:0] {SIN_ERROR, SIMPLE, DOBLE} err_t;

  function automatic logic [2:0] syndrome(input logic [COD_W-1:0] cod);
    logic [2:0] s;
    s[0] = cod[POS_P1] ^ cod[POS_D0] ^ cod[POS_D1] ^ cod[POS_D3];
    s[1] = cod[POS_P2] ^ cod[POS_D0] ^ cod[POS_D2] ^ cod[POS_D3];
    s[2] = cod[POS_P4] ^ cod[POS_D1] ^ cod[POS_D2] ^ cod[POS_D3];
    return s;
  endfunction

  function automatic err_t classify(input logic [2:0] s, input logic pg);
    err_t e;
    if (pg) begin
      e = SIMPLE;
    end else if (s != 3'd0) begin
      e = DOBLE;
    end else begin
      e = SIN_ERROR;
    end
    return e;
  endfunction

endpackage

// File: rtl/calc_sindrome.sv
// Combinational syndrome and global parity of an extended Hamming(8,4) word.
module calc_sindrome
  import pkg_hamming::*;
(
  input  logic [COD_W-1:0] cod,
  output logic [2:0]       s,
  output logic             pg
);

  assign s  = syndrome(cod);
  assign pg = ^cod;

endmodule

// File: rtl/modulo_corrector.sv
// SEC/DED correction stage: two-stage valid/ready pipeline with saturating
// single/double error counters.
module modulo_corrector
  import pkg_hamming::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COD_W-1:0] in_cod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COD_W-1:0] out_cod,
  output logic [2:0]       sindrome,
  output logic             err_simple,
  output logic             err_doble,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_simple,
  output logic [CNT_W-1:0] cnt_doble
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             en;
  logic             xfer;
  logic [2:0]       syn_in;
  logic             pg_in;

  logic             valid_q;
  logic [COD_W-1:0] cod_q;
  logic [2:0]       syn_q;
  logic             pg_q;

  err_t             err_c;
  logic [COD_W-1:0] cor_c;

  // Both stages advance together; a full output with no taker freezes the pipe.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign xfer     = out_valid && out_ready;

  calc_sindrome u_calc_sindrome (
    .cod (in_cod),
    .s   (syn_in),
    .pg  (pg_in)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      cod_q   <= '0;
      syn_q   <= '0;
      pg_q    <= 1'b0;
    end else if (en) begin
      valid_q <= in_valid;
      cod_q   <= in_cod;
      syn_q   <= syn_in;
      pg_q    <= pg_in;
    end
  end

  always_comb begin
    err_c = classify(syn_q, pg_q);
    cor_c = cod_q;
    if (err_c == SIMPLE) begin
      if (syn_q == 3'd0) begin
        cor_c[POS_PG] = ~cod_q[POS_PG];
      end else begin
        cor_c = cod_q ^ (COD_W'(1) << (syn_q - 3'd1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_cod    <= '0;
      sindrome   <= '0;
      err_simple <= 1'b0;
      err_doble  <= 1'b0;
    end else if (en) begin
      out_valid  <= valid_q;
      out_cod    <= cor_c;
      sindrome   <= syn_q;
      err_simple <= valid_q && (err_c == SIMPLE);
      err_doble  <= valid_q && (err_c == DOBLE);
    end
  end

  // Counting on the transfer edge only makes stalled presentations count once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (clr_cnt) begin
      cnt_simple <= '0;
      cnt_doble  <= '0;
    end else if (xfer) begin
      if (err_simple && cnt_simple != CntMax) cnt_simple <= cnt_simple + 1'b1;
      if (err_doble && cnt_doble != CntMax)   cnt_doble  <= cnt_doble + 1'b1;
    end
  end

endmodule

// File: tb/tb_modulo_corrector.sv
// Directed self-checking bench for modulo_corrector (counters 2 bits wide).
module tb_modulo_corrector;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_cod;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_cod;
  logic [2:0] sindrome;
  logic       err_simple;
  logic       err_doble;
  logic       clr_cnt;
  logic [1:0] cnt_simple;
  logic [1:0] cnt_doble;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  modulo_corrector #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cod     (in_cod),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cod    (out_cod),
    .sindrome   (sindrome),
    .err_simple (err_simple),
    .err_doble  (err_doble),
    .clr_cnt    (clr_cnt),
    .cnt_simple (cnt_simple),
    .cnt_doble  (cnt_doble)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
  endtask

  // One isolated word: accepted on the first edge, visible after the second.
  task automatic send_word(input string tag, input logic [7:0] cod, input logic [7:0] exp_cod,
                           input logic [2:0] exp_syn, input logic exp_s, input logic exp_d,
                           input logic [1:0] exp_cs, input logic [1:0] exp_cd);
    in_valid = 1'b1;
    in_cod   = cod;
    step();
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    step();
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_cod"}, 32'(out_cod), 32'(exp_cod));
    check_eq({tag, "_syn"}, 32'(sindrome), 32'(exp_syn));
    check_eq({tag, "_simple"}, 32'(err_simple), 32'(exp_s));
    check_eq({tag, "_doble"}, 32'(err_doble), 32'(exp_d));
    step();
    check_eq({tag, "_drained"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_cnt_s"}, 32'(cnt_simple), 32'(exp_cs));
    check_eq({tag, "_cnt_d"}, 32'(cnt_doble), 32'(exp_cd));
  endtask

  logic [7:0] words [3]   = '{8'h55, 8'h45, 8'h56};
  logic [7:0] exp_out [3] = '{8'h55, 8'h55, 8'h56};
  logic [2:0] exp_syn [3] = '{3'd0, 3'd5, 3'd3};
  logic       exp_s [3]   = '{1'b0, 1'b1, 1'b0};
  logic       exp_d [3]   = '{1'b0, 1'b0, 1'b1};

  initial begin
    int idx;
    int ng;
    logic acc;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cod    = 8'h00;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_cod", 32'(out_cod), 32'd0);
    check_eq("rst_sindrome", 32'(sindrome), 32'd0);
    check_eq("rst_err_simple", 32'(err_simple), 32'd0);
    check_eq("rst_err_doble", 32'(err_doble), 32'd0);
    check_eq("rst_cnt_simple", 32'(cnt_simple), 32'd0);
    check_eq("rst_cnt_doble", 32'(cnt_doble), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    send_word("clean",  8'h55, 8'h55, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0);
    send_word("single", 8'h45, 8'h55, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0);
    send_word("pgbit",  8'hD5, 8'h55, 3'd0, 1'b1, 1'b0, 2'd2, 2'd0);
    send_word("double", 8'h56, 8'h56, 3'd3, 1'b0, 1'b1, 2'd2, 2'd1);

    clear_counters();
    check_eq("clr_cnt_s", 32'(cnt_simple), 32'd0);
    check_eq("clr_cnt_d", 32'(cnt_doble), 32'd0);

    // Back-to-back stream with out_ready low for cycles 2..4.
    idx = 0;
    ng  = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c < 5);
      in_valid  = (idx < 3);
      in_cod    = (idx < 3) ? words[idx] : 8'h00;
      #1;
      if (c >= 2 && c < 5) begin
        check_eq("bp_in_ready_stall", 32'(in_ready), 32'd0);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        check_eq("bp_hold_cod", 32'(out_cod), 32'(exp_out[ng]));
        check_eq("bp_hold_simple", 32'(err_simple), 32'(exp_s[ng]));
      end
      if (out_valid && out_ready) begin
        if (ng < 3) begin
          check_eq("bp_cod", 32'(out_cod), 32'(exp_out[ng]));
          check_eq("bp_syn", 32'(sindrome), 32'(exp_syn[ng]));
          check_eq("bp_simple", 32'(err_simple), 32'(exp_s[ng]));
          check_eq("bp_doble", 32'(err_doble), 32'(exp_d[ng]));
        end
        ng++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("bp_word_count", 32'(ng), 32'd3);
    check_eq("bp_cnt_s", 32'(cnt_simple), 32'd1);
    check_eq("bp_cnt_d", 32'(cnt_doble), 32'd1);

    // Saturation: five single-error words into a 2-bit counter.
    clear_counters();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_cod   = 8'h45;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    check_eq("sat_cnt_s", 32'(cnt_simple), 32'd3);

    // Clear coincident with a single-error transfer wins.
    in_valid = 1'b1;
    in_cod   = 8'h45;
    step();
    in_valid = 1'b0;
    step();
    check_eq("clrpri_valid", 32'(out_valid), 32'd1);
    check_eq("clrpri_simple", 32'(err_simple), 32'd1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check_eq("clrpri_cnt_s", 32'(cnt_simple), 32'd0);
    send_word("after_clr", 8'h45, 8'h55, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0);

    // Reset with two words in flight.
    in_valid = 1'b1;
    in_cod   = 8'h55;
    step();
    in_cod   = 8'h45;
    step();
    in_valid = 1'b0;
    check_eq("midrst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_cod", 32'(out_cod), 32'd0);
    check_eq("midrst_cnt_s", 32'(cnt_simple), 32'd0);
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq("midrst_no_output", 32'(out_valid), 32'd0);
    end
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
